// File: rtl/kproc_pkg.sv
// Shared types for the kproc accumulator core: opcode and FSM state enums,
// plus instruction-width helpers used by the core's parameter list.
package kproc_pkg;

  localparam int OPC_W           = 4;
  localparam int IMM_W_DEFAULT   = 4;
  localparam int INSTR_W_DEFAULT = OPC_W + IMM_W_DEFAULT;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LDA   = 4'h1,
    OP_LDB   = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_MOVBA = 4'h5,
    OP_OUT   = 4'h6,
    OP_JMP   = 4'h7,
    OP_JC    = 4'h8,
    OP_JZ    = 4'h9,
    OP_JNC   = 4'hA,
    OP_HALT  = 4'hB,
    OP_CALL  = 4'hC,
    OP_RET   = 4'hD,
    OP_RSV_E = 4'hE,
    OP_RSV_F = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_OUT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  function automatic int instr_width(input int imm_w);
    return OPC_W + imm_w;
  endfunction

endpackage

// File: rtl/kproc_alu.sv
// Combinational add/subtract unit for the kproc core; subtraction is a + ~b + 1,
// so carry=1 on subtract means no borrow occurred.
module kproc_alu #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             zero
);

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;

  assign w_b_eff = sub ? ~b : b;
  assign w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, sub};
  assign y       = w_sum[WIDTH-1:0];
  assign carry   = w_sum[WIDTH];
  assign zero    = (w_sum[WIDTH-1:0] == '0);

endmodule

// File: rtl/kproc_core.sv
// kproc accumulator core: RUN / WAIT_OUT / HALT FSM with a stalling result port.
// Define KPROC_CALL_EN to add a one-entry link register with CALL (0xC) / RET (0xD).
module kproc_core
  import kproc_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int PC_W    = 4,
  parameter  int IMM_W   = 4,
  localparam int INSTR_W = instr_width(IMM_W)
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    instr_addr,
  input  logic [INSTR_W-1:0] instr_data,
  output logic [WIDTH-1:0]   ra_out,
  output logic [WIDTH-1:0]   rb_out,
  output logic [WIDTH-1:0]   result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               flag_c,
  output logic               flag_z,
  output logic               halted
);

  state_e           r_state;
  logic [PC_W-1:0]  r_pc;
  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic [WIDTH-1:0] r_ro;
  logic             r_out_valid;
  logic             r_c;
  logic             r_z;

  state_e           w_state_next;
  logic [PC_W-1:0]  w_pc_next;
  logic [WIDTH-1:0] w_ra_next;
  logic [WIDTH-1:0] w_rb_next;
  logic [WIDTH-1:0] w_ro_next;
  logic             w_out_valid_next;
  logic             w_c_next;
  logic             w_z_next;

`ifdef KPROC_CALL_EN
  logic [PC_W-1:0]  r_lr;
  logic [PC_W-1:0]  w_lr_next;
`endif

  opcode_e          w_opcode;
  logic [IMM_W-1:0] w_operand;
  logic [WIDTH-1:0] w_imm;
  logic [PC_W-1:0]  w_target;
  logic [PC_W-1:0]  w_pc_inc;
  logic [WIDTH-1:0] w_alu_y;
  logic             w_alu_c;
  logic             w_alu_z;

  assign w_opcode  = opcode_e'(instr_data[INSTR_W-1 -: OPC_W]);
  assign w_operand = instr_data[IMM_W-1:0];
  assign w_imm     = WIDTH'(w_operand);
  assign w_target  = w_operand[PC_W-1:0];
  assign w_pc_inc  = r_pc + PC_W'(1);

  kproc_alu #(.WIDTH(WIDTH)) u_alu (
    .a     (r_ra),
    .b     (r_rb),
    .sub   (w_opcode == OP_SUB),
    .y     (w_alu_y),
    .carry (w_alu_c),
    .zero  (w_alu_z)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_pc        <= '0;
      r_ra        <= '0;
      r_rb        <= '0;
      r_ro        <= '0;
      r_out_valid <= 1'b0;
      r_c         <= 1'b0;
      r_z         <= 1'b0;
`ifdef KPROC_CALL_EN
      r_lr        <= '0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_ra        <= w_ra_next;
      r_rb        <= w_rb_next;
      r_ro        <= w_ro_next;
      r_out_valid <= w_out_valid_next;
      r_c         <= w_c_next;
      r_z         <= w_z_next;
`ifdef KPROC_CALL_EN
      r_lr        <= w_lr_next;
`endif
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_ra_next        = r_ra;
    w_rb_next        = r_rb;
    w_ro_next        = r_ro;
    w_out_valid_next = r_out_valid;
    w_c_next         = r_c;
    w_z_next         = r_z;
`ifdef KPROC_CALL_EN
    w_lr_next        = r_lr;
`endif
    case (r_state)
      ST_RUN: begin
        w_pc_next = w_pc_inc;
        case (w_opcode)
          OP_LDA:   w_ra_next = w_imm;
          OP_LDB:   w_rb_next = w_imm;
          OP_ADD, OP_SUB: begin
            w_ra_next = w_alu_y;
            w_c_next  = w_alu_c;
            w_z_next  = w_alu_z;
          end
          OP_MOVBA: w_rb_next = r_ra;
          OP_OUT: begin
            w_ro_next        = r_ra;
            w_out_valid_next = 1'b1;
            w_state_next     = ST_WAIT_OUT;
          end
          OP_JMP:   w_pc_next = w_target;
          // Conditional jumps see the flags as they stood before this instruction.
          OP_JC:    if (r_c)  w_pc_next = w_target;
          OP_JZ:    if (r_z)  w_pc_next = w_target;
          OP_JNC:   if (!r_c) w_pc_next = w_target;
          OP_HALT: begin
            w_pc_next    = r_pc;
            w_state_next = ST_HALT;
          end
`ifdef KPROC_CALL_EN
          OP_CALL: begin
            w_lr_next = w_pc_inc;
            w_pc_next = w_target;
          end
          OP_RET:   w_pc_next = r_lr;
`endif
          default: ;
        endcase
      end
      ST_WAIT_OUT: begin
        if (r_out_valid && out_ready) begin
          w_out_valid_next = 1'b0;
          w_state_next     = ST_RUN;
        end
      end
      ST_HALT: begin
        if (r_out_valid && out_ready) w_out_valid_next = 1'b0;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  assign instr_addr = r_pc;
  assign ra_out     = r_ra;
  assign rb_out     = r_rb;
  assign result     = r_ro;
  assign out_valid  = r_out_valid;
  assign flag_c     = r_c;
  assign flag_z     = r_z;
  assign halted     = (r_state == ST_HALT);

endmodule

// File: tb/tb_kproc_core.sv
// Directed bench for kproc_core with an instruction-level reference model
// compared against the DUT on every falling edge outside reset.
module tb_kproc_core;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] instr_addr;
  logic [7:0] instr_data;
  logic [7:0] ra_out, rb_out, result;
  logic       out_valid, out_ready = 1'b0;
  logic       flag_c, flag_z, halted;

  logic [7:0] mem [16];
  int passed = 0;
  int total  = 0;

  // reference model state
  int m_pc, m_ra, m_rb, m_ro, m_lr;
  bit m_valid, m_c, m_z, m_halt, m_wait;

  int vcount, vres, edges, subcount;

  always #5 clk = ~clk;

  assign instr_data = mem[instr_addr];

  kproc_core #(.WIDTH(8), .PC_W(4), .IMM_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr_addr (instr_addr),
    .instr_data (instr_data),
    .ra_out     (ra_out),
    .rb_out     (rb_out),
    .result     (result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .flag_c     (flag_c),
    .flag_z     (flag_z),
    .halted     (halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  // Instruction-level model: one architectural step per rising edge.
  always @(posedge clk or posedge reset) begin : model
    int op, opd, npc, sum;
    if (reset) begin
      m_pc <= 0; m_ra <= 0; m_rb <= 0; m_ro <= 0; m_lr <= 0;
      m_valid <= 0; m_c <= 0; m_z <= 0; m_halt <= 0; m_wait <= 0;
    end else if (m_halt || m_wait) begin
      if (m_valid && out_ready) begin
        m_valid <= 0;
        m_wait  <= 0;
      end
    end else begin
      op  = int'(mem[m_pc][7:4]);
      opd = int'(mem[m_pc][3:0]);
      npc = (m_pc + 1) % 16;
      case (op)
        1: m_ra <= opd;
        2: m_rb <= opd;
        3: begin
          sum = m_ra + m_rb;
          m_ra <= sum % 256; m_c <= (sum > 255); m_z <= (sum % 256 == 0);
        end
        4: begin
          sum = (m_ra - m_rb + 256) % 256;
          m_ra <= sum; m_c <= (m_ra >= m_rb); m_z <= (sum == 0);
        end
        5: m_rb <= m_ra;
        6: begin m_ro <= m_ra; m_valid <= 1; m_wait <= 1; end
        7: npc = opd;
        8: if (m_c) npc = opd;
        9: if (m_z) npc = opd;
        10: if (!m_c) npc = opd;
        11: begin m_halt <= 1; npc = m_pc; end
`ifdef KPROC_CALL_EN
        12: begin m_lr <= npc; npc = opd; end
        13: npc = m_lr;
`endif
        default: ;
      endcase
      m_pc <= npc;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("pc", instr_addr, m_pc);
      chk("ra", ra_out, m_ra);
      chk("rb", rb_out, m_rb);
      chk("result", result, m_ro);
      chk("out_valid", out_valid, m_valid);
      chk("flag_c", flag_c, m_c);
      chk("flag_z", flag_z, m_z);
      chk("halted", halted, m_halt);
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic clear_prog;
    for (int i = 0; i < 16; i++) mem[i] = 8'hB0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    wait_edges(1);
    reset = 1'b0;
  endtask

  // Runs until halted (bounded); counts out_valid cycles and SUB fetches at PC 2.
  task automatic wait_halt(input int budget);
    edges = 0; vcount = 0; vres = 0; subcount = 0;
    while (!halted && edges < budget) begin
      wait_edges(1);
      edges++;
      if (out_valid) begin vcount++; vres = int'(result); end
      if (!halted && instr_addr == 4'd2 && mem[2][7:4] == 4'h4) subcount++;
    end
    chk("halt_reached", halted, 1'b1);
  endtask

  initial begin
    // Async reset while stalled in WAIT_OUT
    clear_prog();
    mem[0] = 8'h15; mem[1] = 8'h60; mem[2] = 8'h00;
    out_ready = 1'b0;
    do_reset();
    wait_edges(2);
    chk("t1_valid_before", out_valid, 1'b1);
    chk("t1_pc_before", instr_addr, 4'd2);
    #1 reset = 1'b1;
    #1;
    chk("t1_rst_pc", instr_addr, 4'd0);
    chk("t1_rst_valid", out_valid, 1'b0);
    chk("t1_rst_result", result, 8'd0);
    chk("t1_rst_ra", ra_out, 8'd0);
    chk("t1_rst_flags", {flag_c, flag_z, halted}, 3'b000);
    wait_edges(1);
    reset = 1'b0;
    wait_edges(1);
    chk("t1_run_pc", instr_addr, 4'd1);
    chk("t1_run_ra", ra_out, 8'd5);
    $display("txn reset-in-wait_out done");

    // LDA 5; LDB 3; ADD; OUT; HALT with ready high
    clear_prog();
    mem[0] = 8'h15; mem[1] = 8'h23; mem[2] = 8'h30; mem[3] = 8'h60; mem[4] = 8'hB0;
    out_ready = 1'b1;
    do_reset();
    wait_halt(30);
    chk("t2_pulses", vcount, 1);
    chk("t2_result", vres, 8);
    chk("t2_flags", {flag_c, flag_z}, 2'b00);
    chk("t2_edges", edges, 6);
    chk("t2_pc", instr_addr, 4'd4);
    $display("txn add-out result=%0d pulses=%0d", vres, vcount);

    // SUB borrow then ADD carry
    clear_prog();
    mem[0] = 8'h10; mem[1] = 8'h21; mem[2] = 8'h40; mem[3] = 8'h2F; mem[4] = 8'h30; mem[5] = 8'hB0;
    do_reset();
    wait_edges(3);
    chk("t3_sub_ra", ra_out, 8'hFF);
    chk("t3_sub_c", flag_c, 1'b0);
    wait_halt(30);
    chk("t3_add_ra", ra_out, 8'h0E);
    chk("t3_add_c", flag_c, 1'b1);
    chk("t3_add_z", flag_z, 1'b0);
    $display("txn sub-add ra=%0h c=%0b", ra_out, flag_c);

    // Countdown loop from 3
    clear_prog();
    mem[0] = 8'h13; mem[1] = 8'h21; mem[2] = 8'h40; mem[3] = 8'h95; mem[4] = 8'h72; mem[5] = 8'hB0;
    do_reset();
    wait_halt(40);
    chk("t4_iters", subcount, 3);
    chk("t4_z", flag_z, 1'b1);
    chk("t4_c", flag_c, 1'b1);
    chk("t4_edges", edges, 11);
    chk("t4_pc", instr_addr, 4'd5);
    $display("txn countdown iters=%0d edges=%0d", subcount, edges);

    // OUT stalled by out_ready low for 5 cycles
    clear_prog();
    mem[0] = 8'h17; mem[1] = 8'h60; mem[2] = 8'h19; mem[3] = 8'hB0;
    out_ready = 1'b0;
    do_reset();
    wait_edges(2);
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid", out_valid, 1'b1);
      chk("t5_hold_result", result, 8'd7);
      chk("t5_hold_pc", instr_addr, 4'd2);
      wait_edges(1);
    end
    out_ready = 1'b1;
    wait_edges(1);
    out_ready = 1'b0;
    chk("t5_accept_valid", out_valid, 1'b0);
    chk("t5_accept_pc", instr_addr, 4'd2);
    wait_edges(1);
    chk("t5_resume_ra", ra_out, 8'd9);
    chk("t5_resume_pc", instr_addr, 4'd3);
    wait_halt(10);
    $display("txn out-stall result=%0d", result);

    // CALL 0xA at PC 2, RET at 0xA
    clear_prog();
    mem[0] = 8'h11; mem[1] = 8'h00; mem[2] = 8'hCA; mem[3] = 8'h22; mem[4] = 8'hB0; mem[10] = 8'hD0;
    do_reset();
    wait_edges(3);
`ifdef KPROC_CALL_EN
    chk("t6_after_call_pc", instr_addr, 4'd10);
`else
    chk("t6_after_call_pc", instr_addr, 4'd3);
`endif
    wait_halt(20);
    chk("t6_rb", rb_out, 8'd2);
    chk("t6_pc", instr_addr, 4'd4);
`ifdef KPROC_CALL_EN
    chk("t6_edges", edges, 3);
`else
    chk("t6_edges", edges, 2);
`endif
    $display("txn call-ret pc=%0d", instr_addr);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
